// File: rtl/systolic_array_ctrl_if.sv
// Control, operand-addressing and result-handshake bundle of the systolic array sequencer.
interface systolic_array_ctrl_if #(
  parameter int unsigned DIM = 8
);
  localparam int unsigned ROW_W = $clog2(DIM);

  // Job control
  logic             start;
  logic             clear_c;
  logic             abort;
  logic             busy;
  logic             done;
  // C preload
  logic             c_wr_en;
  logic [ROW_W-1:0] c_wr_row;
  logic             c_wr_zero;
  // A/B operand streaming
  logic             ab_rd_en;
  logic [ROW_W-1:0] ab_rd_addr;
  logic             ab_feed_valid;
  logic             arr_en;
  // Result readout
  logic             c_rd_valid;
  logic [ROW_W-1:0] c_rd_row;
  logic             c_rd_ready;

  // Job requester / array datapath side
  modport master (
    output start, clear_c, abort, c_rd_ready,
    input  busy, done, c_wr_en, c_wr_row, c_wr_zero,
           ab_rd_en, ab_rd_addr, ab_feed_valid, arr_en,
           c_rd_valid, c_rd_row
  );

  // Sequencer side
  modport slave (
    input  start, clear_c, abort, c_rd_ready,
    output busy, done, c_wr_en, c_wr_row, c_wr_zero,
           ab_rd_en, ab_rd_addr, ab_feed_valid, arr_en,
           c_rd_valid, c_rd_row
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a DIM x DIM tpumac systolic array: C preload, A/B streaming
// with diagonal skew drain, and ready/valid readout of the result rows.
module systolic_array_ctrl #(
  parameter int unsigned DIM = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  systolic_array_ctrl_if.slave bus
);
  localparam int unsigned ROW_W = $clog2(DIM);
  // COMPUTE counts up to 3*DIM-2, wider than a row index
  localparam int unsigned CNT_W = $clog2(3 * DIM);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] LAST_T   = CNT_W'(3 * DIM - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_C  = 3'd1,
    COMPUTE = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             c_wr_en;
    logic [ROW_W-1:0] c_wr_row;
    logic             c_wr_zero;
    logic             ab_rd_en;
    logic [ROW_W-1:0] ab_rd_addr;
    logic             ab_feed_valid;
    logic             arr_en;
    logic             c_rd_valid;
    logic [ROW_W-1:0] c_rd_row;
  } ctrl_out_t;

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             clr_q, clr_n;
  ctrl_out_t        out_q, out_n;
  logic             rd_hs;

  // A result row is consumed when the registered valid meets ready
  assign rd_hs = out_q.c_rd_valid && bus.c_rd_ready;

  // State register, phase counter, latched clear_c and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      clr_q   <= clr_n;
      out_q   <= out_n;
    end
  end

  // Next state and counter; the counter restarts at zero on every state entry
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    clr_n   = clr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = LOAD_C;
          cnt_n   = '0;
          clr_n   = bus.clear_c;
        end
      end
      LOAD_C: begin
        if (cnt_q == LAST_ROW) begin
          state_n = COMPUTE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      COMPUTE: begin
        if (cnt_q == LAST_T) begin
          state_n = READ;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end
      READ: begin
        if (rd_hs) begin
          if (cnt_q == LAST_ROW) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_ONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Abort wins over any progress outside IDLE
    if ((state_q != IDLE) && bus.abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  // Output decode of the upcoming state so every pin is registered in step with the state
  always_comb begin
    out_n      = '0;
    out_n.busy = (state_n != IDLE);
    unique case (state_n)
      LOAD_C: begin
        out_n.c_wr_en   = 1'b1;
        out_n.c_wr_row  = ROW_W'(cnt_n);
        out_n.c_wr_zero = clr_n;
      end
      COMPUTE: begin
        // Operand reads for t < N; data lands one cycle later; en drains the skew
        out_n.ab_rd_en      = (cnt_n < N_CNT);
        out_n.ab_rd_addr    = (cnt_n < N_CNT) ? ROW_W'(cnt_n) : '0;
        out_n.ab_feed_valid = (cnt_n >= CNT_ONE) && (cnt_n <= N_CNT);
        out_n.arr_en        = (cnt_n >= CNT_ONE);
      end
      READ: begin
        out_n.c_rd_valid = 1'b1;
        out_n.c_rd_row   = ROW_W'(cnt_n);
      end
      DONE: begin
        out_n.done = 1'b1;
      end
      default: begin
        out_n.busy = 1'b0;
      end
    endcase
  end

  assign bus.busy          = out_q.busy;
  assign bus.done          = out_q.done;
  assign bus.c_wr_en       = out_q.c_wr_en;
  assign bus.c_wr_row      = out_q.c_wr_row;
  assign bus.c_wr_zero     = out_q.c_wr_zero;
  assign bus.ab_rd_en      = out_q.ab_rd_en;
  assign bus.ab_rd_addr    = out_q.ab_rd_addr;
  assign bus.ab_feed_valid = out_q.ab_feed_valid;
  assign bus.arr_en        = out_q.arr_en;
  assign bus.c_rd_valid    = out_q.c_rd_valid;
  assign bus.c_rd_row      = out_q.c_rd_row;

  // Preload writes and accumulation must never collide in a PE
  a_wr_vs_en: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_q.c_wr_en && out_q.arr_en));

  // Operand buffers are only addressed while the array is computing
  a_rd_in_compute: assert property (@(posedge clk) disable iff (!rst_n)
    out_q.ab_rd_en |-> (state_q == COMPUTE));

  // busy mirrors the FSM being away from IDLE
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    out_q.busy == (state_q != IDLE));

  // done is a single-cycle pulse
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    out_q.done |=> !out_q.done);
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: per-cycle control reference plus a behavioural
// DIM x DIM tpumac array with skew and operand/C buffers checked against A*B+C.
module tb_systolic_array_ctrl;
  localparam int unsigned DIM = 4;
  localparam int N      = DIM;
  localparam int RD_OFF = 4 * N - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.DIM(DIM)) bus ();

  systolic_array_ctrl #(.DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rd_cnt   = 0;
  bit chk_en   = 1'b0;
  bit data_ok  = 1'b1;

  // matrices, expected result and behavioural array state
  int a_m [N][N];
  int b_m [N][N];
  int c_m [N][N];
  int exp_m [N][N];
  int a_r [N][N];
  int b_r [N][N];
  int c_r [N][N];
  int a_sk [N][N];
  int b_sk [N][N];
  int a_q [N];
  int b_q [N];

  // control reference: cycles since job start, rows consumed, latched clear
  int m_off = -1;
  int m_row = 0;
  bit m_clr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input logic busy, input logic done, input logic wr,
                                       input logic zero, input logic rd, input logic feed,
                                       input logic en, input logic vld,
                                       input int wrow, input int addr, input int rrow);
    return {busy, done, wr, zero, rd, feed, en, vld, 8'(wrow), 8'(addr), 8'(rrow)};
  endfunction

  function automatic logic [31:0] dut_outs();
    return pack(bus.busy, bus.done, bus.c_wr_en, bus.c_wr_zero, bus.ab_rd_en,
                bus.ab_feed_valid, bus.arr_en, bus.c_rd_valid,
                int'(bus.c_wr_row), int'(bus.ab_rd_addr), int'(bus.c_rd_row));
  endfunction

  // Expected pins from the job timeline: N preload, 3N-1 compute, readout, done
  function automatic logic [31:0] model_outs();
    logic busy, done, wr, zero, rd, feed, en, vld;
    int wrow, addr, rrow, t;
    busy = 1'b0; done = 1'b0; wr = 1'b0; zero = 1'b0;
    rd = 1'b0; feed = 1'b0; en = 1'b0; vld = 1'b0;
    wrow = 0; addr = 0; rrow = 0;
    if (m_off >= 0) begin
      busy = 1'b1;
      if (m_off < N) begin
        wr = 1'b1; wrow = m_off; zero = m_clr;
      end else if (m_off < RD_OFF) begin
        t    = m_off - N;
        rd   = (t < N);
        addr = (t < N) ? t : 0;
        feed = (t >= 1) && (t <= N);
        en   = (t >= 1);
      end else if (m_row < N) begin
        vld = 1'b1; rrow = m_row;
      end else begin
        done = 1'b1;
      end
    end
    return pack(busy, done, wr, zero, rd, feed, en, vld, wrow, addr, rrow);
  endfunction

  always @(posedge clk) cyc++;

  // Control reference update on each sampled edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_off = -1;
    end else if (m_off < 0) begin
      if (bus.start && !bus.abort) begin
        m_off = 0; m_row = 0; m_clr = bus.clear_c;
      end
    end else if (bus.abort || (m_off == RD_OFF && m_row == N)) begin
      m_off = -1;
    end else if (m_off < RD_OFF) begin
      m_off++;
    end else if (bus.c_rd_ready) begin
      m_row++;
    end
  end

  // Compare every pin each cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) check("ctrl", dut_outs(), model_outs());
    if (bus.done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // Behavioural array: registered operand buffers, skew chains, PEs, C buffer
  always @(posedge clk) begin : array_model
    int fa [N];
    int fb [N];
    int sa [N];
    int sb [N];
    int na [N][N];
    int nb [N][N];
    int ai, bi, row, adr;
    if (bus.c_rd_valid && bus.c_rd_ready) begin
      rd_cnt++;
      row = int'(bus.c_rd_row);
      if (data_ok)
        for (int j = 0; j < N; j++) check("res", 32'(c_r[row][j]), 32'(exp_m[row][j]));
    end
    for (int i = 0; i < N; i++) begin
      fa[i] = bus.ab_feed_valid ? a_q[i] : 0;
      fb[i] = bus.ab_feed_valid ? b_q[i] : 0;
      if (i == 0) begin
        sa[i] = fa[i]; sb[i] = fb[i];
      end else begin
        sa[i] = a_sk[i][i-1]; sb[i] = b_sk[i][i-1];
      end
    end
    if (bus.arr_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) ai = sa[i]; else ai = a_r[i][j-1];
          if (i == 0) bi = sb[j]; else bi = b_r[i-1][j];
          c_r[i][j] = c_r[i][j] + ai * bi;
          na[i][j] = ai;
          nb[i][j] = bi;
        end
      a_r = na;
      b_r = nb;
      for (int i = 1; i < N; i++) begin
        for (int s = i - 1; s > 0; s--) begin
          a_sk[i][s] = a_sk[i][s-1];
          b_sk[i][s] = b_sk[i][s-1];
        end
        a_sk[i][0] = fa[i];
        b_sk[i][0] = fb[i];
      end
    end
    if (bus.c_wr_en) begin
      row = int'(bus.c_wr_row);
      for (int j = 0; j < N; j++) c_r[row][j] = bus.c_wr_zero ? 0 : c_m[row][j];
    end
    if (bus.ab_rd_en) begin
      adr = int'(bus.ab_rd_addr);
      for (int i = 0; i < N; i++) begin
        a_q[i] = a_m[i][adr];
        b_q[i] = b_m[adr][i];
      end
    end
    // an interrupted job leaves operands in flight; the next job's results are not trusted
    if (!rst_n || (bus.abort && bus.busy)) data_ok = 1'b0;
    if (bus.done) data_ok = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_expect(input bit clr);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_m[i][j] = clr ? 0 : c_m[i][j];
        for (int k = 0; k < N; k++) exp_m[i][j] += a_m[i][k] * b_m[k][j];
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = int'($urandom_range(255));
        b_m[i][j] = int'($urandom_range(255));
        c_m[i][j] = int'($urandom_range(1000));
      end
  endtask

  // One job to completion; returns cycles from the start cycle to the done cycle
  task automatic run_job(input bit clr, input int ready_pct, input int stall_row,
                         input int stall_len, input int glitch_at, output int lat);
    int k0, d0, n, stalls;
    set_expect(clr);
    d0 = done_cnt; rd_cnt = 0; stalls = stall_len;
    bus.start = 1'b1; bus.clear_c = clr; bus.c_rd_ready = 1'b1; k0 = cyc;
    step();
    bus.start = 1'b0; bus.clear_c = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      if (stalls > 0 && bus.c_rd_valid && int'(bus.c_rd_row) == stall_row) begin
        bus.c_rd_ready = 1'b0;
        stalls--;
      end else begin
        bus.c_rd_ready = ($urandom_range(99) < ready_pct);
      end
      if (cyc - k0 == glitch_at) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
      n++;
    end
    check("job_done", 32'(done_cnt - d0), 32'd1);
    check("rows_read", 32'(rd_cnt), 32'(N));
    lat = last_done_cyc - k0;
    bus.c_rd_ready = 1'b1;
  endtask

  // Start a job and abort it 'at' cycles after the start cycle
  task automatic abort_job(input int at);
    int k0, d0;
    d0 = done_cnt;
    bus.start = 1'b1; bus.clear_c = 1'b1; bus.c_rd_ready = 1'b1; k0 = cyc;
    step();
    bus.start = 1'b0; bus.clear_c = 1'b0;
    while (cyc - k0 < at) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_idle", dut_outs(), 32'h0);
    repeat (4) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
  endtask

  initial begin : main
    int lat, k0, d0, n;
    bus.start = 1'b0; bus.clear_c = 1'b0; bus.abort = 1'b0; bus.c_rd_ready = 1'b1;
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    check("reset", dut_outs(), 32'h0);
    rst_n = 1'b1;
    step();

    // identity A, B = 1..16, C buffer all 5
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = i * N + j + 1;
        c_m[i][j] = 5;
      end
    run_job(1'b0, 100, -1, 0, -1, lat);
    check("lat_c5", 32'(lat), 32'd20);
    run_job(1'b1, 100, -1, 0, -1, lat);
    check("lat_zero", 32'(lat), 32'd20);

    // three stalled cycles on row 2 delay done by three
    run_job(1'b1, 100, 2, 3, -1, lat);
    check("lat_stall", 32'(lat), 32'd23);

    // abort at COMPUTE t=4, then a clean job
    abort_job(N + 5);
    run_job(1'b0, 100, -1, 0, -1, lat);
    check("lat_after_abort", 32'(lat), 32'd20);

    // start and abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_idle", 32'(bus.busy), 32'd0);
    step();

    // start held high: one job, then a second only after IDLE
    set_expect(1'b1);
    d0 = done_cnt; k0 = cyc; n = 0;
    bus.start = 1'b1; bus.clear_c = 1'b1;
    while (done_cnt - d0 < 2 && n < 200) begin
      step(); n++;
      if (cyc - k0 >= 24) begin
        bus.start = 1'b0; bus.clear_c = 1'b0;
      end
    end
    bus.start = 1'b0; bus.clear_c = 1'b0;
    check("held_two_jobs", 32'(done_cnt - d0), 32'd2);
    check("held_second_done", 32'(last_done_cyc - k0), 32'd41);
    repeat (3) step();
    check("held_idle", 32'(bus.busy), 32'd0);

    // synchronous reset during READ
    d0 = done_cnt; n = 0;
    bus.start = 1'b1; bus.clear_c = 1'b1;
    step();
    bus.start = 1'b0; bus.clear_c = 1'b0;
    while (!(bus.c_rd_valid && bus.c_rd_row == 1) && n < 100) begin
      step(); n++;
    end
    check("reach_read", 32'(bus.c_rd_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_read", dut_outs(), 32'h0);
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // reset glitch between edges is not seen
    run_job(1'b1, 100, -1, 0, 3, lat);
    check("lat_glitch", 32'(lat), 32'd20);

    // randomized matrices, clears, backpressure and aborts
    for (int r = 0; r < 14; r++) begin
      fill_random();
      if ($urandom_range(3) == 0) abort_job(int'($urandom_range(1, 4 * N + 2)));
      run_job(1'($urandom_range(1)), 65, -1, 0, -1, lat);
      check("lat_min", 32'(lat >= 20), 32'd1);
      repeat ($urandom_range(2)) step();
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
